// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: steps LED patterns and gates the pacing timer.
// Define LED_MODE_SEQUENCER_BOUNCE_EN to build the BOUNCE mode.
module led_mode_sequencer #(
    parameter int LED_COUNT  = 3,
    parameter int STEP_TICKS = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 next_pressed,
    input  logic                 hold_pressed,
    input  logic                 timer_elapsed,
    output logic                 timer_enabled,
    output logic [LED_COUNT-1:0] led,
    output logic [2:0]           mode,
    output logic                 paused
);
    localparam int CW = $clog2(STEP_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_BLINK   = 3'd1;
    localparam logic [2:0] S_CH_UP   = 3'd2;
    localparam logic [2:0] S_CH_DN   = 3'd3;
    localparam logic [2:0] S_BOUNCE  = 3'd4;

    localparam logic [LED_COUNT-1:0] LED_LSB = LED_COUNT'(1);
    localparam logic [LED_COUNT-1:0] LED_MSB = {1'b1, {(LED_COUNT-1){1'b0}}};

    logic [2:0]           r_mode;
    logic [2:0]           w_mode_nxt;
    logic [LED_COUNT-1:0] r_led;
    logic [LED_COUNT-1:0] w_led_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 r_paused;
    logic                 w_paused_nxt;
    logic                 r_ten;
    logic                 w_ten_nxt;
    logic                 w_legal;
    logic                 w_change;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
    logic                 r_dir_dn;
    logic                 w_dir_dn_nxt;

    assign w_legal = (r_mode <= S_BOUNCE);
`else
    assign w_legal = (r_mode <= S_CH_DN);
`endif

    // Any mode change, including recovery from an illegal code, reloads
    assign w_change = next_pressed || !w_legal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= S_OFF;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (!w_legal) begin
            w_mode_nxt = S_OFF;
        end else if (next_pressed) begin
            case (r_mode)
                S_OFF:   w_mode_nxt = S_BLINK;
                S_BLINK: w_mode_nxt = S_CH_UP;
                S_CH_UP: w_mode_nxt = S_CH_DN;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
                S_CH_DN: w_mode_nxt = S_BOUNCE;
`endif
                default: w_mode_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        w_led_nxt    = r_led;
        w_cnt_nxt    = r_cnt;
        w_paused_nxt = r_paused;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
        w_dir_dn_nxt = r_dir_dn;
`endif
        if (w_change) begin
            w_cnt_nxt    = '0;
            w_paused_nxt = 1'b0;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
            w_dir_dn_nxt = 1'b0;
`endif
            case (w_mode_nxt)
                S_CH_UP:  w_led_nxt = LED_LSB;
                S_CH_DN:  w_led_nxt = LED_MSB;
                S_BOUNCE: w_led_nxt = LED_LSB;
                default:  w_led_nxt = '0;
            endcase
        end else if (hold_pressed && r_mode != S_OFF) begin
            w_paused_nxt = !r_paused;
        end else if (timer_elapsed && r_mode != S_OFF && !r_paused) begin
            if (r_cnt != LAST) begin
                w_cnt_nxt = r_cnt + ONE;
            end else begin
                w_cnt_nxt = '0;
                case (r_mode)
                    S_BLINK: w_led_nxt = ~r_led;
                    S_CH_UP: w_led_nxt = {r_led[LED_COUNT-2:0], r_led[LED_COUNT-1]};
                    S_CH_DN: w_led_nxt = {r_led[0], r_led[LED_COUNT-1:1]};
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
                    S_BOUNCE: begin
                        // Reverse at either end, so the end LED is lit once
                        if (!r_dir_dn) begin
                            if (r_led[LED_COUNT-1]) begin
                                w_dir_dn_nxt = 1'b1;
                                w_led_nxt    = r_led >> 1;
                            end else begin
                                w_led_nxt    = r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                w_dir_dn_nxt = 1'b0;
                                w_led_nxt    = r_led << 1;
                            end else begin
                                w_led_nxt    = r_led >> 1;
                            end
                        end
                    end
`endif
                    default: w_led_nxt = r_led;
                endcase
            end
        end
        w_ten_nxt = (w_mode_nxt != S_OFF) && !w_paused_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_led    <= '0;
            r_cnt    <= '0;
            r_paused <= 1'b0;
            r_ten    <= 1'b0;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
            r_dir_dn <= 1'b0;
`endif
        end else begin
            r_led    <= w_led_nxt;
            r_cnt    <= w_cnt_nxt;
            r_paused <= w_paused_nxt;
            r_ten    <= w_ten_nxt;
`ifdef LED_MODE_SEQUENCER_BOUNCE_EN
            r_dir_dn <= w_dir_dn_nxt;
`endif
        end
    end

    assign mode          = r_mode;
    assign led           = r_led;
    assign paused        = r_paused;
    assign timer_enabled = r_ten;
endmodule
